// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered opcode/immediate decode stage with valid/ready handshake
// Optional feature macro: DECODE_PREFIX_EN (immediate-prefix FSM widening the next immediate)
module decode_stage #(
  parameter int INST_W = 8,
  parameter int OPC_W = 4,
  parameter int IMM_W = 8,
  parameter int SHORT_W = 2,
  parameter int LONG_W = 4,
  parameter logic [OPC_W-1:0] PREFIX_OP = OPC_W'(4'hF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_imm_long,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [IMM_W-1:0]  out_imm,
  output logic              out_prefixed
);

  logic [OPC_W-1:0]          opcode;
  logic signed [SHORT_W-1:0] short_field;
  logic signed [LONG_W-1:0]  long_field;
  logic [IMM_W-1:0]          imm_short;
  logic [IMM_W-1:0]          imm_long;
  logic                      accept;

  assign opcode      = in_inst[INST_W-1 -: OPC_W];
  assign short_field = in_inst[SHORT_W-1:0];
  assign long_field  = in_inst[LONG_W-1:0];

  // Size casts of signed fields sign-extend to the output width
  assign imm_short = IMM_W'(short_field);
  assign imm_long  = IMM_W'(long_field);

  // A new instruction may enter only when the output slot is free or being drained
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef DECODE_PREFIX_EN
  typedef enum logic {IDLE, PFX} state_t;

  state_t                      state;
  logic [LONG_W-1:0]           prefix_q;
  logic signed [2*LONG_W-1:0]  pfx_field;
  logic [IMM_W-1:0]            imm_pfx;
  logic                        is_prefix;

  assign is_prefix = (opcode == PREFIX_OP);
  assign pfx_field = {prefix_q, in_inst[LONG_W-1:0]};
  assign imm_pfx   = IMM_W'(pfx_field);

  // Output register plus prefix FSM; a prefix accept drains any consumed output but produces none
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_opcode   <= '0;
      out_imm      <= '0;
      out_prefixed <= 1'b0;
      state        <= IDLE;
      prefix_q     <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_prefixed <= 1'b0;
      state        <= IDLE;
      prefix_q     <= '0;
    end else if (accept && is_prefix) begin
      prefix_q <= in_inst[LONG_W-1:0];
      state    <= PFX;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= opcode;
      if (state == PFX) begin
        out_imm      <= imm_pfx;
        out_prefixed <= 1'b1;
      end else begin
        out_imm      <= in_imm_long ? imm_long : imm_short;
        out_prefixed <= 1'b0;
      end
      state    <= IDLE;
      prefix_q <= '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  logic unused_prefix_op;

  assign unused_prefix_op = (opcode == PREFIX_OP);
  assign out_prefixed     = 1'b0;

  // Output register: load on accept, drop valid once consumed without a replacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_imm    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= opcode;
      out_imm    <= in_imm_long ? imm_long : imm_short;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
